// File: rtl/fpu_pkg.sv
// Shared FPU command-path definitions: frame parser states, opcode values
// and the default frame sync nibble.
package fpu_pkg;

    localparam int         DSIZE_DEF = 8;
    localparam int         OPW_DEF   = 32;
    localparam logic [3:0] SYNC_DEF  = 4'hA;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_OPA = 2'd1,
        S_OPB = 2'd2,
        S_OUT = 2'd3
    } state_t;

endpackage

// File: rtl/fpu_cmd_unpack.sv
// Pops header/operand beats from the async command FIFO read port and
// presents each completed {op, a, b} frame to the FPU issue stage.
module fpu_cmd_unpack
    import fpu_pkg::*;
#(
    parameter int         DSIZE = DSIZE_DEF,
    parameter int         OPW   = OPW_DEF,
    parameter logic [3:0] SYNC  = SYNC_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [3:0]       cmd_op,
    output logic [OPW-1:0]   cmd_a,
    output logic [OPW-1:0]   cmd_b,
    output logic             sync_err
);

    localparam int BEATS = OPW / DSIZE;
    localparam int CW    = $clog2(BEATS) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [OPW-1:0]   sr;
    logic [OPW-1:0]   sr_shift;
    logic             last_beat;
    logic             hdr_ok;

    // The pop strobe is purely combinational so the FIFO advances on the
    // same edge that samples rdata; nothing is popped while a frame waits.
    assign rinc      = ~rempty & (state != S_OUT);
    assign sr_shift  = {rdata, sr[OPW-1:DSIZE]};
    assign last_beat = (cnt == CW'(BEATS - 1));
    assign hdr_ok    = (rdata[3:0] == SYNC);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_HDR: if (rinc && hdr_ok)          state_nxt = S_OPA;
            S_OPA: if (rinc && last_beat)       state_nxt = S_OPB;
            S_OPB: if (rinc && last_beat)       state_nxt = S_OUT;
            S_OUT: if (cmd_valid && cmd_ready)  state_nxt = S_HDR;
            default:                            state_nxt = S_HDR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the partial shift register is reset too, so a frame cut short by
    // reset leaves no residue in the next one.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt       <= '0;
            sr        <= '0;
            cmd_op    <= '0;
            cmd_a     <= '0;
            cmd_b     <= '0;
            cmd_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            unique case (state)
                S_HDR: begin
                    if (rinc) begin
                        if (hdr_ok) begin
                            cmd_op <= rdata[7:4];
                            cnt    <= '0;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end
                S_OPA, S_OPB: begin
                    if (rinc) begin
                        sr <= sr_shift;
                        if (last_beat) begin
                            cnt <= '0;
                            if (state == S_OPA) begin
                                cmd_a <= sr_shift;
                            end else begin
                                cmd_b     <= sr_shift;
                                cmd_valid <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_cmd_unpack.sv
// Self-checking bench for fpu_cmd_unpack: a queue-backed FIFO model, a
// frame-level reference model, table-driven frames and randomized traffic.
module tb_fpu_cmd_unpack;
    import fpu_pkg::*;

    localparam int DSIZE = 8;
    localparam int OPW   = 32;
    localparam int BEATS = OPW / DSIZE;
    localparam int NBEAT = 1 + 2 * BEATS;
    localparam int FBITS = DSIZE * NBEAT;

    logic             rclk;
    logic             rrst_n;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [OPW-1:0]   cmd_a;
    logic [OPW-1:0]   cmd_b;
    logic             sync_err;

    fpu_cmd_unpack #(.DSIZE(DSIZE), .OPW(OPW), .SYNC(SYNC_DEF)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .sync_err  (sync_err)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        logic [FBITS-1:0] beats;
        logic [3:0]       op;
        logic [OPW-1:0]   a;
        logic [OPW-1:0]   b;
    } vec_t;

    vec_t vecs[4];

    logic [DSIZE-1:0] q[$];
    logic [DSIZE-1:0] partial[$];
    int               hs_cyc[$];
    int n_vec, n_err, cyc;
    int n_pops, n_hs, n_sync, n_frames;
    int frame_start, frame_end;
    bit pop_armed, hs_armed, exp_valid, exp_sync;
    logic [3:0]     cur_op;
    logic [OPW-1:0] cur_a, cur_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic present();
        rempty = (q.size() == 0) || !rrst_n;
        rdata  = rempty ? '0 : q[0];
    endtask

    // Reference model: a frame is a good header followed by 2*BEATS bytes;
    // operands are the little-endian sum of their bytes.
    task automatic model_pop(input logic [DSIZE-1:0] b);
        n_pops++;
        if (partial.size() == 0 && b[3:0] != SYNC_DEF) begin
            exp_sync = 1'b1;
        end else begin
            partial.push_back(b);
            if (partial.size() == 1) frame_start = cyc;
            if (partial.size() == NBEAT) begin
                cur_op = partial[0][7:4];
                cur_a  = '0;
                cur_b  = '0;
                for (int i = 0; i < BEATS; i++) begin
                    cur_a = cur_a + (OPW'(partial[1 + i]) << (DSIZE * i));
                    cur_b = cur_b + (OPW'(partial[1 + BEATS + i]) << (DSIZE * i));
                end
                exp_valid = 1'b1;
                frame_end = cyc;
                n_frames++;
                partial.delete();
            end
        end
    endtask

    // One clock: check at the falling edge, then advance the models just
    // after the rising edge.
    task automatic tick();
        @(negedge rclk);
        check("rinc", 32'(rinc), 32'(!rempty && !exp_valid));
        check("cmd_valid", 32'(cmd_valid), 32'(exp_valid));
        check("sync_err", 32'(sync_err), 32'(exp_sync));
        if (exp_valid) begin
            check("cmd_op", 32'(cmd_op), 32'(cur_op));
            check("cmd_a", cmd_a, cur_a);
            check("cmd_b", cmd_b, cur_b);
        end
        if (sync_err) n_sync++;
        pop_armed = rinc;
        hs_armed  = cmd_valid && cmd_ready;
        if (hs_armed) hs_cyc.push_back(cyc);
        @(posedge rclk);
        #1;
        cyc++;
        exp_sync = 1'b0;
        if (hs_armed) begin
            exp_valid = 1'b0;
            n_hs++;
        end
        if (pop_armed) begin
            if (q.size() == 0) check("pop_from_empty", 32'd1, 32'd0);
            else model_pop(q.pop_front());
        end
        present();
    endtask

    task automatic push_frame(input logic [FBITS-1:0] f, input int nb);
        for (int i = 0; i < nb; i++) q.push_back(f[FBITS-1-DSIZE*i -: DSIZE]);
        present();
    endtask

    task automatic wait_valid(input int max, input string name);
        int n = 0;
        while (!cmd_valid && n < max) begin
            tick();
            n++;
        end
        check(name, 32'(cmd_valid), 32'd1);
    endtask

    task automatic accept();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    task automatic check_frame(input string name, input int idx);
        check({name, "_op"}, 32'(cmd_op), 32'(vecs[idx].op));
        check({name, "_a"}, cmd_a, vecs[idx].a);
        check({name, "_b"}, cmd_b, vecs[idx].b);
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        q.delete();
        partial.delete();
        exp_valid = 1'b0;
        exp_sync  = 1'b0;
        present();
        #1;
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_op", 32'(cmd_op), 32'd0);
        check("rst_a", cmd_a, 32'd0);
        check("rst_b", cmd_b, 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        repeat (2) tick();
        rrst_n = 1'b1;
        present();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, s0, h0, pushed;
        logic [7:0] bh;
        logic [FBITS-1:0] rf;

        vecs[0] = '{72'h1A_00_00_80_3F_00_00_00_40, OP_ADD, 32'h3F80_0000, 32'h4000_0000};
        vecs[1] = '{72'h2A_78_56_34_12_EF_BE_AD_DE, OP_SUB, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[2] = '{72'h3A_FF_FF_FF_FF_01_00_00_00, OP_MUL, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[3] = '{72'hFA_00_00_00_80_00_00_00_00, 4'hF,   32'h8000_0000, 32'h0000_0000};

        n_vec = 0; n_err = 0; cyc = 0;
        n_pops = 0; n_hs = 0; n_sync = 0; n_frames = 0;
        cmd_ready = 1'b0;
        do_reset();
        repeat (2) tick();

        // Table: each frame alone, latency from first pop to cmd_valid.
        for (int v = 0; v < 4; v++) begin
            push_frame(vecs[v].beats, NBEAT);
            wait_valid(40, "tbl_valid_timeout");
            check("tbl_span", 32'(frame_end - frame_start + 1), 32'(NBEAT));
            check_frame("tbl", v);
            accept();
        end

        // Back-pressure with a second frame queued behind the first.
        push_frame(vecs[0].beats, NBEAT);
        push_frame(vecs[1].beats, NBEAT);
        wait_valid(40, "bp_valid_timeout");
        repeat (20) tick();
        check("bp_held_queue", 32'(q.size()), 32'(NBEAT));
        check_frame("bp1", 0);
        accept();
        wait_valid(40, "bp2_valid_timeout");
        check_frame("bp2", 1);
        accept();

        // Starved FIFO: one beat then three empty cycles.
        p0 = n_pops;
        for (int i = 0; i < NBEAT; i++) begin
            q.push_back(vecs[0].beats[FBITS-1-DSIZE*i -: DSIZE]);
            present();
            repeat (4) tick();
        end
        wait_valid(10, "drip_valid_timeout");
        check("drip_pops", 32'(n_pops - p0), 32'(NBEAT));
        check_frame("drip", 0);
        accept();

        // Bad header followed by a good frame.
        s0 = n_sync;
        q.push_back(8'h37);
        push_frame(vecs[1].beats, NBEAT);
        wait_valid(40, "bad_valid_timeout");
        check("bad_sync_pulses", 32'(n_sync - s0), 32'd1);
        check_frame("bad", 1);
        accept();

        // Reset after five beats of a frame, then a fresh frame.
        push_frame(vecs[1].beats, 5);
        repeat (8) tick();
        do_reset();
        push_frame(vecs[0].beats, NBEAT);
        wait_valid(40, "rst_valid_timeout");
        check_frame("post_rst", 0);
        accept();

        // Streaming: four frames back-to-back with cmd_ready held high.
        hs_cyc.delete();
        for (int v = 0; v < 4; v++) push_frame(vecs[v].beats, NBEAT);
        cmd_ready = 1'b1;
        for (int n = 0; n < 100 && hs_cyc.size() < 4; n++) tick();
        cmd_ready = 1'b0;
        check("stream_handshakes", 32'(hs_cyc.size()), 32'd4);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("stream_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd10);

        // Randomized traffic: gaps, stray bad headers, random back-pressure.
        h0 = n_hs;
        pushed = 0;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                bh = 8'($urandom);
                if (bh[3:0] == SYNC_DEF) bh[3:0] = 4'h5;
                q.push_back(bh);
            end
            rf = {4'($urandom), SYNC_DEF, 32'($urandom), 32'($urandom)};
            for (int i = 0; i < NBEAT; i++) begin
                q.push_back(rf[FBITS-1-DSIZE*i -: DSIZE]);
                present();
                repeat ($urandom_range(0, 2)) begin
                    cmd_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            pushed++;
        end
        for (int n = 0; n < 2000 && (n_hs - h0) < pushed; n++) begin
            cmd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        cmd_ready = 1'b0;
        check("rand_handshakes", 32'(n_hs - h0), 32'(pushed));
        check("frames_vs_handshakes", 32'(n_frames), 32'(n_hs));
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
